// File: rtl/genius_controller.sv
// Genius (Simon) game sequencer: plays the pattern for the current level,
// then checks the player's presses against pattern memory.
module genius_controller #(
  parameter int unsigned SEQ_LEN         = 16,
  parameter int unsigned SHOW_ON_CYCLES  = 25000000,
  parameter int unsigned SHOW_OFF_CYCLES = 12500000,
  parameter int unsigned INPUT_TIMEOUT   = 250000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       bt0,
  input  logic       bt1,
  input  logic       bt2,
  output logic [3:0] seq_index,
  input  logic [1:0] seq_value,
  output logic       show_en,
  output logic [1:0] show_value,
  output logic [4:0] level,
  output logic [3:0] step,
  output logic [2:0] state_code,
  output logic       win,
  output logic       lose
);

  localparam int unsigned MAX_A   = (SHOW_ON_CYCLES > SHOW_OFF_CYCLES) ? SHOW_ON_CYCLES : SHOW_OFF_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > INPUT_TIMEOUT) ? MAX_A : INPUT_TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(SHOW_ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(SHOW_OFF_CYCLES - 1);
  localparam logic [TMR_W-1:0] IN_LAST  = TMR_W'(INPUT_TIMEOUT - 1);
  localparam logic [4:0]       LVL_MAX  = 5'(SEQ_LEN);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHOW_ON  = 3'd1,
    S_SHOW_OFF = 3'd2,
    S_INPUT    = 3'd3,
    S_LEVEL_UP = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       level_q, level_d;
  logic [3:0]       step_q, step_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             start_prev_q;
  logic [2:0]       btn_prev_q;
  logic             show_en_q, win_q, lose_q;

  logic [2:0] btn_s;
  logic [2:0] rise_btn_s;
  logic       rise_start_s;
  logic       last_step_s;
  logic       one_hot_s;
  logic [1:0] press_val_s;
  logic       good_s;
  logic       timer_clr_s;
  logic       timer_run_s;

  assign btn_s        = {bt2, bt1, bt0};
  assign rise_btn_s   = btn_s & ~btn_prev_q;
  assign rise_start_s = start & ~start_prev_q;
  assign last_step_s  = ({1'b0, step_q} == (level_q - 5'd1));
  assign one_hot_s    = (rise_btn_s != 3'd0) && ((rise_btn_s & (rise_btn_s - 3'd1)) == 3'd0);
  assign good_s       = one_hot_s && (seq_value != 2'd3) && (press_val_s == seq_value);

  // Map a single button rise to the value it represents.
  always_comb begin
    case (rise_btn_s)
      3'b001:  press_val_s = 2'd0;
      3'b010:  press_val_s = 2'd1;
      3'b100:  press_val_s = 2'd2;
      default: press_val_s = 2'd3;
    endcase
  end

  // Next-state, level/step and timer control.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    step_d      = step_q;
    timer_clr_s = 1'b0;
    timer_run_s = 1'b1;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        timer_run_s = 1'b0;
        if (rise_start_s) begin
          state_d = S_SHOW_ON;
          level_d = 5'd1;
          step_d  = 4'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_SHOW_ON: begin
        if (timer_q == ON_LAST) begin
          state_d = S_SHOW_OFF;
        end else begin
          state_d = S_SHOW_ON;
        end
      end
      S_SHOW_OFF: begin
        if (timer_q != OFF_LAST) begin
          state_d = S_SHOW_OFF;
        end else if (last_step_s) begin
          state_d = S_INPUT;
          step_d  = 4'd0;
        end else begin
          state_d = S_SHOW_ON;
          step_d  = step_q + 4'd1;
        end
      end
      S_INPUT: begin
        // A press on the timeout cycle takes priority over the timeout.
        if (rise_btn_s != 3'd0) begin
          if (!good_s) begin
            state_d = S_LOSE;
          end else if (last_step_s && (level_q == LVL_MAX)) begin
            state_d = S_WIN;
          end else if (last_step_s) begin
            state_d = S_LEVEL_UP;
            level_d = level_q + 5'd1;
            step_d  = 4'd0;
          end else begin
            step_d      = step_q + 4'd1;
            timer_clr_s = 1'b1;
          end
        end else if (timer_q == IN_LAST) begin
          state_d = S_LOSE;
        end else begin
          state_d = S_INPUT;
        end
      end
      S_LEVEL_UP: begin
        if (timer_q == OFF_LAST) begin
          state_d = S_SHOW_ON;
        end else begin
          state_d = S_LEVEL_UP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        level_d     = 5'd0;
        step_d      = 4'd0;
        timer_run_s = 1'b0;
      end
    endcase

    if ((state_d != state_q) || timer_clr_s || !timer_run_s) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  // State, counters, input history and registered status flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      level_q      <= 5'd0;
      step_q       <= 4'd0;
      timer_q      <= '0;
      start_prev_q <= start;
      btn_prev_q   <= btn_s;
      show_en_q    <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      step_q       <= step_d;
      timer_q      <= timer_d;
      start_prev_q <= start;
      btn_prev_q   <= btn_s;
      show_en_q    <= (state_d == S_SHOW_ON);
      win_q        <= (state_d == S_WIN);
      lose_q       <= (state_d == S_LOSE);
    end
  end

  assign seq_index  = step_q;
  assign show_en    = show_en_q;
  assign show_value = show_en_q ? seq_value : 2'd0;
  assign level      = level_q;
  assign step       = step_q;
  assign state_code = state_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule

// File: tb/tb_genius_controller.sv
// Directed bench for genius_controller with a small pattern memory (0,1,0,2).
module tb_genius_controller;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic       bt0, bt1, bt2;
  logic [3:0] seq_index;
  logic [1:0] seq_value;
  logic       show_en;
  logic [1:0] show_value;
  logic [4:0] level;
  logic [3:0] step;
  logic [2:0] state_code;
  logic       win, lose;

  logic [1:0] mem [0:15];
  int n_checks = 0;
  int n_errors = 0;

  assign seq_value = mem[seq_index];

  genius_controller #(
    .SEQ_LEN(4), .SHOW_ON_CYCLES(4), .SHOW_OFF_CYCLES(2), .INPUT_TIMEOUT(20)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .bt0(bt0), .bt1(bt1), .bt2(bt2),
    .seq_index(seq_index), .seq_value(seq_value),
    .show_en(show_en), .show_value(show_value),
    .level(level), .step(step), .state_code(state_code),
    .win(win), .lose(lose)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_core(input string tag, input int st, input int lvl, input int stp);
    check({tag, ".state"}, 32'(state_code), 32'(st));
    check({tag, ".level"}, 32'(level), 32'(lvl));
    check({tag, ".step"},  32'(step), 32'(stp));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input int b);
    bt0 = (b == 0);
    bt1 = (b == 1);
    bt2 = (b == 2);
    tick();
    bt0 = 1'b0;
    bt1 = 1'b0;
    bt2 = 1'b0;
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_core("start", 1, 1, 0);
  endtask

  task automatic show_level(input int lvl);
    for (int i = 0; i < lvl; i++) begin
      for (int c = 0; c < 4; c++) begin
        check_core("show_on", 1, lvl, i);
        check("show_on.en", 32'(show_en), 32'd1);
        check("show_on.val", 32'(show_value), 32'(mem[i]));
        tick();
      end
      for (int c = 0; c < 2; c++) begin
        check_core("show_off", 2, lvl, i);
        check("show_off.en", 32'(show_en), 32'd0);
        check("show_off.val", 32'(show_value), 32'd0);
        tick();
      end
    end
    check_core("input_entry", 3, lvl, 0);
  endtask

  task automatic answer_level(input int lvl);
    for (int i = 0; i < lvl; i++) begin
      check_core("input", 3, lvl, i);
      press(int'(mem[i]));
    end
    if (lvl < 4) begin
      check_core("level_up0", 4, lvl + 1, 0);
      tick();
      check_core("level_up1", 4, lvl + 1, 0);
      tick();
      check_core("level_up_exit", 1, lvl + 1, 0);
    end else begin
      check_core("win", 5, 4, 3);
      check("win.flag", 32'(win), 32'd1);
      check("win.lose", 32'(lose), 32'd0);
    end
  endtask

  task automatic wait_state(input int st, input int budget);
    int n;
    n = 0;
    while ((int'(state_code) != st) && (n < budget)) begin
      tick();
      n++;
    end
    check("wait_state", 32'(state_code), 32'(st));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 2'd3;
    mem[0] = 2'd0; mem[1] = 2'd1; mem[2] = 2'd0; mem[3] = 2'd2;
    reset_n = 1'b0; start = 1'b0; bt0 = 1'b0; bt1 = 1'b0; bt2 = 1'b0;
    tick();
    tick();
    check_core("reset", 0, 0, 0);
    check("reset.show_en", 32'(show_en), 32'd0);
    check("reset.win_lose", 32'({win, lose}), 32'd0);
    reset_n = 1'b1;
    tick();
    check_core("idle", 0, 0, 0);

    // Full game to WIN
    start_game();
    for (int l = 1; l <= 4; l++) begin
      show_level(l);
      answer_level(l);
    end
    tick();
    check_core("win_hold", 5, 4, 3);
    check("win_hold.flag", 32'(win), 32'd1);

    // Wrong press at level 2, step 1
    start_game();
    show_level(1);
    answer_level(1);
    show_level(2);
    press(0);
    check_core("wrong_pre", 3, 2, 1);
    press(2);
    check_core("wrong", 6, 2, 1);
    check("wrong.lose", 32'(lose), 32'd1);
    tick();
    check_core("lose_hold", 6, 2, 1);

    // Timeout at level 1
    start_game();
    show_level(1);
    repeat (19) tick();
    check_core("pre_timeout", 3, 1, 0);
    tick();
    check_core("timeout", 6, 1, 0);
    check("timeout.lose", 32'(lose), 32'd1);

    // Correct press on the timeout cycle wins the race
    start_game();
    show_level(1);
    repeat (19) tick();
    press(0);
    check_core("late_press", 4, 2, 0);
    tick();
    tick();
    check_core("lvl2_show", 1, 2, 0);

    // Ignored events, then simultaneous presses
    bt2 = 1'b1; start = 1'b1;
    tick();
    bt2 = 1'b0; start = 1'b0;
    check_core("ignored_show", 1, 2, 0);
    wait_state(3, 40);
    check_core("lvl2_input", 3, 2, 0);
    press(0);
    check_core("lvl2_step1", 3, 2, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_core("ignored_start", 3, 2, 1);
    bt0 = 1'b1; bt1 = 1'b1;
    tick();
    bt0 = 1'b0; bt1 = 1'b0;
    check_core("double", 6, 2, 1);

    // Reset mid-game at level 3 with start held through release
    start_game();
    show_level(1);
    answer_level(1);
    show_level(2);
    answer_level(2);
    check_core("lvl3_show", 1, 3, 0);
    reset_n = 1'b0; start = 1'b1;
    tick();
    check_core("mid_reset", 0, 0, 0);
    check("mid_reset.show", 32'({show_en, show_value}), 32'd0);
    check("mid_reset.wl", 32'({win, lose}), 32'd0);
    check("mid_reset.idx", 32'(seq_index), 32'd0);
    reset_n = 1'b1;
    tick();
    tick();
    check_core("held_start", 0, 0, 0);
    start = 1'b0;
    tick();
    check_core("start_low", 0, 0, 0);
    start_game();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/genius_controller.md
Name: genius_controller

Overview:
- Game-sequencing FSM for the Genius (Simon) board game.
- Steps the pattern memory index to play the current level's pattern on the display, then collects player presses on bt0..bt2 and compares each against memory.
- Advances the level on success; ends in WIN or LOSE.
- Sits between the pattern memory (index out, 2-bit value back, combinational) and the 7-segment/LED display logic.

Parameters:
- SEQ_LEN, 16, pattern length and maximum level (1..16)
- SHOW_ON_CYCLES, 25000000, cycles each pattern element is displayed
- SHOW_OFF_CYCLES, 12500000, blank gap after each element and before a new level
- INPUT_TIMEOUT, 250000000, maximum cycles allowed between player presses

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  level input (switch); a rising edge starts or restarts a game
- bt0  in  1  player button for value 0, level, debounced externally
- bt1  in  1  player button for value 1
- bt2  in  1  player button for value 2
- seq_index  out  4  pattern memory address (= step)
- seq_value  in  2  pattern value at seq_index, valid the same cycle
- show_en  out  1  high while a pattern element must be displayed
- show_value  out  2  element to display (= seq_value when show_en=1, else 0)
- level  out  5  current level, 0 in IDLE, 1..SEQ_LEN during play
- step  out  4  position within the current level
- state_code  out  3  IDLE=0, SHOW_ON=1, SHOW_OFF=2, INPUT=3, LEVEL_UP=4, WIN=5, LOSE=6
- win  out  1  high in WIN
- lose  out  1  high in LOSE

Behaviour:
- Reset (reset_n=0 at a clock edge) gives:
  - state=IDLE; level, step, timer and all outputs = 0.
  - Edge-detect history registers load the current start/bt0..bt2 values, so inputs held through reset produce no edge.
  - Reset mid-game aborts to IDLE immediately.
- Edge detection: rise_x = x & ~x_prev, registered history.
  - If start rises at edge t, the next state appears after edge t.
  - A button press counts only in INPUT.
- Timer: one counter, cleared on every state entry. A timed state exits when timer==N-1, so it lasts exactly N cycles.
- seq_index = step in all states.
- IDLE: outputs idle. rise_start → level=1, step=0 → SHOW_ON.
- SHOW_ON: show_en=1, show_value=seq_value. Lasts SHOW_ON_CYCLES → SHOW_OFF.
- SHOW_OFF: show_en=0 for SHOW_OFF_CYCLES, then:
  - if step==level-1: step=0 → INPUT;
  - else step+1 → SHOW_ON.
- INPUT: let press = any rise among bt0..bt2.
  - Exactly one rise, matching value equal to seq_value:
    - if step==level-1 and level==SEQ_LEN → WIN;
    - if step==level-1 and level<SEQ_LEN → LEVEL_UP;
    - otherwise step+1, timer cleared, stay in INPUT.
  - Two or more simultaneous rises, a mismatch, or seq_value==3 → LOSE.
  - No press and timer==INPUT_TIMEOUT-1 → LOSE.
  - A press on the timeout cycle is evaluated as a press; timeout is ignored that cycle.
- LEVEL_UP: level+1 and step=0 on entry. Blank for SHOW_OFF_CYCLES → SHOW_ON.
- WIN / LOSE: level and step frozen; win or lose held high. rise_start → same as the IDLE start action (level=1, step=0 → SHOW_ON).
- rise_start is ignored in SHOW_ON, SHOW_OFF, INPUT and LEVEL_UP. Button rises are ignored outside INPUT.
- level never exceeds SEQ_LEN; step never exceeds level-1. No wrap-around of step or level is reachable.

Test Plan:
- Bench setup for all scenarios: SEQ_LEN=4, SHOW_ON_CYCLES=4, SHOW_OFF_CYCLES=2, INPUT_TIMEOUT=20; pattern memory model 0,1,0,2.
- Reset then start rise:
  - state_code=1 one cycle after the edge, level=1, show_en=1 and show_value=0 for exactly 4 cycles;
  - then 2 blank cycles, then state_code=3 with step=0.
- Full win: press the correct buttons at every level.
  - Level 2 shows 0,1; level 4 shows 0,1,0,2 with 2-cycle gaps.
  - After the 4th correct press at level 4: win=1, state_code=5, level=4.
- Wrong press: at level 2, step 1, press bt2 (expected 1).
  - Next cycle lose=1, state_code=6; level=2 and step=1 held.
- Timeout: enter INPUT at level 1 with no press.
  - lose=1 exactly 20 cycles after INPUT entry.
  - A variant pressing the correct button on the 20th cycle reaches LEVEL_UP instead.
- Simultaneous presses and ignored events:
  - bt0 and bt1 rise in the same cycle in INPUT → LOSE.
  - Button presses during SHOW_ON and start rises mid-game → no state, level or step change.
- Reset and restart:
  - Assert reset_n=0 during SHOW_ON at level 3 → all outputs 0, IDLE.
  - Keep start held high through reset release → stays in IDLE until start falls and rises again.
  - A start rise from LOSE restarts at level=1.
